// File: rtl/ram_io_responder_pkg.sv
// Shared constants and types for the CPU-bus RAM/IO responder.
package ram_io_responder_pkg;

  localparam int       IO_SEL_BIT  = 17;
  localparam logic [2:0] IO_DATA_OFS = 3'h0;
  localparam logic [2:0] IO_STAT_OFS = 3'h4;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_TX_OVF      = 2;
  localparam int ST_TX_EMPTY    = 3;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       tx_empty;
    logic       tx_ovf;
    logic       tx_full;
    logic       rx_nonempty;
  } status_t;

endpackage

// File: rtl/ram_io_responder_fifo.sv
// Byte FIFO with DEPTH entries, combinational head; pointers carry one extra wrap bit.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp, rp;
  logic        do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // A push into a full FIFO is refused even when a pop happens the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];
  assign count   = wp - rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ram_io_responder.sv
// Target of the byte-wide CPU memory bus: byte RAM plus an IO window with TX/RX FIFOs.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int    ADDR_W     = 17,
  parameter int    FIFO_DEPTH = 16,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int FAW = $clog2(FIFO_DEPTH);

  logic [7:0]        ram [2**ADDR_W];
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_q, io_q;
  logic              rd_ram_q;
  logic              io_sel, data_rd, data_wr, stat_rd, stat_wr;
  logic              tx_full, tx_empty, rx_full, rx_empty, tx_ovf;
  logic [7:0]        rx_head;
  logic [FAW:0]      tx_count, rx_count;
  status_t           status;
  logic              unused;

  assign ram_a   = mem_a[ADDR_W-1:0];
  assign io_sel  = mem_a[IO_SEL_BIT];
  assign data_rd = io_sel && !mem_wr && (mem_a[2:0] == IO_DATA_OFS);
  assign data_wr = io_sel &&  mem_wr && (mem_a[2:0] == IO_DATA_OFS);
  assign stat_rd = io_sel && !mem_wr && (mem_a[2:0] == IO_STAT_OFS);
  assign stat_wr = io_sel &&  mem_wr && (mem_a[2:0] == IO_STAT_OFS);
  assign unused  = ^{mem_a[31:IO_SEL_BIT+1], tx_count, rx_count};

  assign status = '{rsvd: 4'h0, tx_empty: tx_empty, tx_ovf: tx_ovf,
                    tx_full: tx_full, rx_nonempty: !rx_empty};

  // RAM has no reset so it maps onto block memory and keeps contents across rst.
  always_ff @(posedge clk) begin
    if (mem_wr && !io_sel) ram[ram_a] <= mem_din;
    ram_q <= ram[ram_a];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ram_q <= 1'b0;
      io_q     <= 8'h00;
    end else begin
      rd_ram_q <= !mem_wr && !io_sel;
      if (data_rd)      io_q <= rx_empty ? 8'h00 : rx_head;
      else if (stat_rd) io_q <= status;
      else              io_q <= 8'h00;
    end
  end

  assign mem_dout = rd_ram_q ? ram_q : io_q;

  always_ff @(posedge clk) begin
    if (rst)                          tx_ovf <= 1'b0;
    else if (data_wr && tx_full)      tx_ovf <= 1'b1;
    else if (stat_wr && mem_din[7])   tx_ovf <= 1'b0;
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(data_wr), .pop(tx_ready), .din(mem_din),
    .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_valid), .pop(data_rd), .din(rx_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder with a queue-based reference model checked every cycle.
module tb_ram_io_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a = 32'h0002_0001;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int errors = 0;
  int checks = 0;

  ram_io_responder #(.ADDR_W(17), .FIFO_DEPTH(16), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_wr(mem_wr), .mem_din(mem_din),
    .mem_dout(mem_dout), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RAM array, FIFO queues, sticky overflow, expected read byte.
  logic [7:0] ram_m [131072];
  logic [7:0] txq [$];
  logic [7:0] rxq [$];
  bit         ovf = 1'b0;
  logic [7:0] exp_dout = 8'h00;
  bit         live = 1'b0;

  always @(posedge clk) begin
    int txn, rxn;
    logic io;
    logic [2:0] ofs;
    if (rst) begin
      txq.delete(); rxq.delete(); ovf = 1'b0; exp_dout = 8'h00; live = 1'b1;
    end else begin
      txn = txq.size(); rxn = rxq.size();
      io = mem_a[17]; ofs = mem_a[2:0];
      if (mem_wr)             exp_dout = 8'h00;
      else if (!io)           exp_dout = ram_m[mem_a[16:0]];
      else if (ofs == 3'h0)   exp_dout = (rxn > 0) ? rxq[0] : 8'h00;
      else if (ofs == 3'h4)   exp_dout = {4'h0, txn == 0, ovf, txn == 16, rxn != 0};
      else                    exp_dout = 8'h00;
      if (tx_ready && txn > 0) void'(txq.pop_front());
      if (mem_wr && io && ofs == 3'h0) begin
        if (txn == 16) ovf = 1'b1;
        else txq.push_back(mem_din);
      end
      if (mem_wr && io && ofs == 3'h4 && mem_din[7]) ovf = 1'b0;
      if (!mem_wr && io && ofs == 3'h0 && rxn > 0) void'(rxq.pop_front());
      if (rx_valid && rxn < 16) rxq.push_back(rx_data);
      if (mem_wr && !io) ram_m[mem_a[16:0]] = mem_din;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_dout", mem_dout, exp_dout);
      chk("model_tx_valid", tx_valid, txq.size() != 0);
      if (txq.size() != 0) chk("model_tx_data", tx_data, txq[0]);
      chk("model_rx_ready", rx_ready, rxq.size() < 16);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    mem_a = 32'h0002_0001; mem_wr = 1'b0; mem_din = 8'h00;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_din = d; step(); idle();
  endtask

  task automatic rd(input logic [31:0] a);
    mem_a = a; mem_wr = 1'b0; step(); idle();
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    chk("reset_dout", mem_dout, 8'h00);
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_rx_ready", rx_ready, 1'b1);
    step();

    wr(32'h10, 8'hA5); rd(32'h10);
    chk("ram_a5", mem_dout, 8'hA5);

    wr(32'h0, 8'h11); wr(32'h1, 8'h22); wr(32'h2, 8'h33); wr(32'h3, 8'h44);
    rd(32'h0); chk("b2b_0", mem_dout, 8'h11);
    rd(32'h1); chk("b2b_1", mem_dout, 8'h22);
    rd(32'h2); chk("b2b_2", mem_dout, 8'h33);
    rd(32'h3); chk("b2b_3", mem_dout, 8'h44);
    step(); chk("idle_after_reads", mem_dout, 8'h00);

    wr(32'h30000, 8'h41); wr(32'h30000, 8'h42);
    chk("tx_valid_held", tx_valid, 1'b1);
    chk("tx_head_41", tx_data, 8'h41);
    step(); chk("tx_stable_41", tx_data, 8'h41);
    tx_ready = 1'b1; step();
    chk("tx_head_42", tx_data, 8'h42);
    step(); chk("tx_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;
    rd(32'h30004); chk("tx_status_08", mem_dout, 8'h08);

    for (int i = 0; i < 17; i++) wr(32'h30000, 8'h60 + 8'(i));
    rd(32'h30004); chk("ovf_status_06", mem_dout, 8'h06);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", tx_data, 8'h60 + 8'(i));
      step();
    end
    tx_ready = 1'b0;
    chk("ovf_drained", tx_valid, 1'b0);
    rd(32'h30004); chk("ovf_status_0c", mem_dout, 8'h0C);
    wr(32'h30004, 8'h7F); rd(32'h30004); chk("ovf_kept", mem_dout, 8'h0C);
    wr(32'h30004, 8'h80); rd(32'h30004); chk("ovf_cleared", mem_dout, 8'h08);

    wr(32'h30002, 8'h55); rd(32'h30002); chk("other_ofs", mem_dout, 8'h00);
    chk("other_ofs_no_tx", tx_valid, 1'b0);

    rx_data = 8'h5A; rx_valid = 1'b1; step(); rx_valid = 1'b0;
    rd(32'h30004); chk("rx_status_09", mem_dout, 8'h09);
    rd(32'h30000); chk("rx_pop_5a", mem_dout, 8'h5A);
    rd(32'h30000); chk("rx_empty_00", mem_dout, 8'h00);

    rx_data = 8'h33; rx_valid = 1'b1; mem_a = 32'h30000; step();
    rx_valid = 1'b0; idle();
    chk("rx_empty_pushpop", mem_dout, 8'h00);
    rd(32'h30000); chk("rx_pushpop_33", mem_dout, 8'h33);

    rx_data = 8'h11; rx_valid = 1'b1; step();
    rx_data = 8'h22; mem_a = 32'h30000; step();
    rx_valid = 1'b0; idle();
    chk("rx_pushpop_11", mem_dout, 8'h11);
    rd(32'h30004); chk("rx_count_kept", mem_dout, 8'h09);
    rd(32'h30000); chk("rx_pop_22", mem_dout, 8'h22);
    rd(32'h30004); chk("rx_status_empty", mem_dout, 8'h08);

    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'h80 + 8'(i); step();
    end
    chk("rx_backpressure", rx_ready, 1'b0);
    wr(32'h30000, 8'h77);
    mem_a = 32'h10; rst = 1'b1; step();
    rst = 1'b0; rx_valid = 1'b0; idle();
    chk("midrst_dout", mem_dout, 8'h00);
    chk("midrst_rx_ready", rx_ready, 1'b1);
    chk("midrst_tx_valid", tx_valid, 1'b0);
    rd(32'h30004); chk("midrst_status", mem_dout, 8'h08);
    rd(32'h10); chk("midrst_ram_kept", mem_dout, 8'hA5);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
